// File: rtl/vga_rect_renderer.sv
`default_nettype none
// vga_rect_renderer: draws up to N_RECT priority-ordered solid rectangles over a background colour,
// with vsync-committed shadow registers and a 2-cycle pixel pipeline. Rev 1.0
module vga_rect_renderer #(
   parameter int unsigned N_RECT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] x,
   input  logic [8:0] y,
   input  logic       active,
   input  logic       hs,
   input  logic       vs,
   input  logic       wr_en,
   input  logic [4:0] wr_addr,
   input  logic [9:0] wr_data,
   output logic [5:0] rgb,
   output logic       hs_out,
   output logic       vs_out,
   output logic       de_out,
   output logic       commit
);

   localparam logic [4:0] ADDR_BG = 5'd20;
   localparam logic [4:0] ADDR_EN = 5'd21;

   logic [9:0]        sx0_q [N_RECT];
   logic [8:0]        sy0_q [N_RECT];
   logic [9:0]        sx1_q [N_RECT];
   logic [8:0]        sy1_q [N_RECT];
   logic [5:0]        scol_q[N_RECT];
   logic [5:0]        sbg_q;
   logic [N_RECT-1:0] sen_q;

   logic [9:0]        lx0_q [N_RECT];
   logic [8:0]        ly0_q [N_RECT];
   logic [9:0]        lx1_q [N_RECT];
   logic [8:0]        ly1_q [N_RECT];
   logic [5:0]        lcol_q[N_RECT];
   logic [5:0]        lbg_q;
   logic [N_RECT-1:0] len_q;

   logic              vs_q, hs1_q, de1_q;
   logic [N_RECT-1:0] hit_q, hit_d;
   logic [5:0]        col1_q[N_RECT];
   logic [5:0]        bg1_q;
   logic [5:0]        rgb_q, rgb_d;
   logic              hs2_q, vs2_q, de2_q, commit_q;
   logic              commit_w;

   assign commit_w = vs && !vs_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_RECT); i++) begin
            sx0_q[i]  <= '0;
            sy0_q[i]  <= '0;
            sx1_q[i]  <= '0;
            sy1_q[i]  <= '0;
            scol_q[i] <= '0;
         end
         sbg_q <= '0;
         sen_q <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < int'(N_RECT); i++) begin
            if (wr_addr == 5'(5*i))     sx0_q[i]  <= wr_data;
            if (wr_addr == 5'(5*i + 1)) sy0_q[i]  <= wr_data[8:0];
            if (wr_addr == 5'(5*i + 2)) sx1_q[i]  <= wr_data;
            if (wr_addr == 5'(5*i + 3)) sy1_q[i]  <= wr_data[8:0];
            if (wr_addr == 5'(5*i + 4)) scol_q[i] <= wr_data[5:0];
         end
         if (wr_addr == ADDR_BG) sbg_q <= wr_data[5:0];
         if (wr_addr == ADDR_EN) sen_q <= wr_data[N_RECT-1:0];
      end
   end

   // Live set samples the shadow before any same-cycle write lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N_RECT); i++) begin
            lx0_q[i]  <= '0;
            ly0_q[i]  <= '0;
            lx1_q[i]  <= '0;
            ly1_q[i]  <= '0;
            lcol_q[i] <= '0;
         end
         lbg_q    <= '0;
         len_q    <= '0;
         commit_q <= 1'b0;
      end else begin
         commit_q <= commit_w;
         if (commit_w) begin
            for (int i = 0; i < int'(N_RECT); i++) begin
               lx0_q[i]  <= sx0_q[i];
               ly0_q[i]  <= sy0_q[i];
               lx1_q[i]  <= sx1_q[i];
               ly1_q[i]  <= sy1_q[i];
               lcol_q[i] <= scol_q[i];
            end
            lbg_q <= sbg_q;
            len_q <= sen_q;
         end
      end
   end

   always_comb begin
      hit_d = '0;
      for (int i = 0; i < int'(N_RECT); i++) begin
         hit_d[i] = len_q[i] && (x >= lx0_q[i]) && (x < lx1_q[i])
                             && (y >= ly0_q[i]) && (y < ly1_q[i]);
      end
   end

   // Scan from the highest index down so the lowest-index hit wins.
   always_comb begin
      rgb_d = bg1_q;
      for (int i = int'(N_RECT) - 1; i >= 0; i--) begin
         if (hit_q[i]) rgb_d = col1_q[i];
      end
      if (!de1_q) rgb_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q  <= 1'b0;
         hs1_q <= 1'b0;
         de1_q <= 1'b0;
         hit_q <= '0;
         for (int i = 0; i < int'(N_RECT); i++) col1_q[i] <= '0;
         bg1_q <= '0;
         rgb_q <= '0;
         hs2_q <= 1'b0;
         vs2_q <= 1'b0;
         de2_q <= 1'b0;
      end else begin
         vs_q  <= vs;
         hs1_q <= hs;
         de1_q <= active;
         hit_q <= hit_d;
         for (int i = 0; i < int'(N_RECT); i++) col1_q[i] <= lcol_q[i];
         bg1_q <= lbg_q;
         rgb_q <= rgb_d;
         hs2_q <= hs1_q;
         vs2_q <= vs_q;
         de2_q <= de1_q;
      end
   end

   assign rgb    = rgb_q;
   assign hs_out = hs2_q;
   assign vs_out = vs2_q;
   assign de_out = de2_q;
   assign commit = commit_q;

endmodule
`default_nettype wire

// File: doc/vga_rect_renderer.md
Name: vga_rect_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA timing generator.
- Consumes x, y, active, hs and vs, and produces 6-bit RRGGBB pixels plus sync and data-enable outputs delayed to match.
- Draws up to N_RECT solid, priority-ordered rectangles over a background colour.
- The host (Arduino command decoder) writes rectangle geometry through a simple register write port. Writes land in shadow registers and are committed atomically at vsync, so the display never tears.

Parameters:
- N_RECT, 4, number of implemented rectangle slots (1..4). Slots at index N_RECT or above are not implemented: writes to them are ignored and their enable bits read as 0.

Ports:
- clk  input  1  pixel clock, same clock as the timing generator
- rst_n  input  1  asynchronous, active-low reset
- x  input  10  current column from the timing generator; meaningful only while active=1
- y  input  9  current row from the timing generator; meaningful only while active=1
- active  input  1  active-video flag
- hs  input  1  horizontal sync, passed through
- vs  input  1  vertical sync, high during the sync pulse
- wr_en  input  1  register write strobe, one write per cycle
- wr_addr  input  5  register address
- wr_data  input  10  write data, LSB-aligned
- rgb  output  6  pixel colour {R[1:0],G[1:0],B[1:0]}
- hs_out  output  1  hs delayed by 2 cycles
- vs_out  output  1  vs delayed by 2 cycles
- de_out  output  1  active delayed by 2 cycles
- commit  output  1  one-cycle pulse when shadow registers are copied to the live set

Behaviour:
- Register map, rectangle i at base 5*i:
  - +0 x0[9:0]
  - +1 y0[8:0]
  - +2 x1[9:0], exclusive
  - +3 y1[8:0], exclusive
  - +4 colour[5:0]
- Address 20: background colour[5:0]. Address 21: enable[3:0], bit i enables rectangle i.
- Unused addresses and unused upper data bits are ignored.
- Write: when wr_en=1, wr_data goes into the shadow register at wr_addr on the next clk edge.
- Commit:
  - vs is registered once (vs_q). A rising edge is defined as vs=1 and vs_q=0.
  - On a rising edge, every shadow register is copied into its live register and commit pulses high for exactly 1 cycle.
  - If a write and a commit occur in the same cycle, the live set receives the pre-write shadow value. The write still lands in shadow and takes effect at the next commit.
- Rendering uses live registers only; shadow writes never affect the current frame.
- Pipeline stage 1 (registered):
  - Capture active, hs and vs.
  - Compute hit[i] = enable[i] and x0<=x<x1 and y0<=y<y1, using unsigned compares.
  - Capture the live colours.
- Pipeline stage 2 (registered):
  - If de=0, rgb=0.
  - Otherwise rgb = colour of the lowest-index rectangle with hit set; background if no hit.
- Latency: rgb, hs_out, vs_out and de_out all lag their inputs by exactly 2 clk cycles and stay mutually aligned.
- Degenerate rectangles (x0>=x1 or y0>=y1) never hit; this is not an error.
- x1=640 or y1=480 covers up to the last visible column/row. Coordinates beyond the visible area are legal and simply never match an active pixel.
- x and y values during blanking (wrapped values) have no effect because de gates the output.
- Reset (asserted asynchronously, at any time including mid-frame):
  - All shadow and live registers are cleared to 0: all rectangles disabled, all colours 0.
  - Pipeline registers are cleared.
  - rgb=0, hs_out=0, vs_out=0, de_out=0, commit=0, vs_q=0.
- After reset release, the first vs rising edge commits whatever was written.

Test Plan:
- Reset, write no registers, run 2 frames: rgb=0 whenever de_out=1; hs_out/vs_out equal hs/vs delayed 2 cycles; commit pulses once per frame.
- Write bg=6'b000011 and enable=0, then wait for commit: all active pixels = 6'h03 starting the frame after commit; pixels before commit stay 0.
- Rect0 = (100,50)-(110,60) colour 6'h30, enable=1, after commit: pixel (100,50)=6'h30, (109,59)=6'h30, (110,50)=bg, (99,50)=bg, (100,60)=bg.
- Rect0 = (0,0)-(640,480) colour 6'h0C and rect1 = (10,10)-(20,20) colour 6'h30, both enabled: (15,15)=6'h0C (rect0 wins priority); disable rect0 and commit: (15,15)=6'h30.
- Write rect0 colour 6'h3F mid-frame: current frame keeps the old colour; the new colour appears only after the next vs rise. A write issued in the exact commit cycle appears one frame later.
- Degenerate rect (x0=200,x1=200) enabled: never drawn. Assert rst_n low mid-line: outputs go to 0 immediately; after release, enables=0 and only rgb=0 is drawn until new writes are committed.
